// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the fetch PC, issues reads to a 1-cycle synchronous instruction
//   memory and buffers returned words in a 2-entry queue presented to decode
//   over valid/ready. Redirects flush the queue and reload the PC; illegal
//   targets or a PC leaving the memory window park the block in FAULT.
module fetch_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
    parameter int          MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_read_enable,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault
);

    // First byte past the end of instruction memory.
    localparam logic [31:0] SPAN     = 32'(MEM_WORDS) << 2;
    localparam logic [31:0] TOP_ADDR = BASE_ADDR + SPAN;

    typedef enum logic {S_RUN = 1'b0, S_FAULT = 1'b1} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic        armed;        // low for the first cycle after reset so reset outputs are visible
    logic        inflight;     // a read was issued last cycle; its data is on imem_instruction now
    logic [31:0] inflight_pc;
    logic        kill;         // suppresses the return slot right after a redirect
    entry_t      q0, q1;       // q0 is the head presented to decode
    logic [1:0]  count;

    logic        pop, push, issue, pc_ok, target_ok, has_room;
    entry_t      ret;

    // Unsigned window check; 32-bit modulo PC means a wrap lands outside it.
    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE_ADDR) && (a < TOP_ADDR);
    endfunction

    assign pc_ok     = in_range(pc);
    assign target_ok = in_range(redirect_pc) && (redirect_pc[1:0] == 2'b00);

    assign out_valid = (count != 2'd0);
    assign out_pc    = q0.pc;
    assign out_instr = q0.instr;

    assign pop  = out_valid && out_ready;
    // A redirect in the cycle the data returns already drops it; kill covers
    // the slot after the redirect so nothing issued earlier can sneak in.
    assign push = inflight && !kill;
    assign ret  = '{pc: inflight_pc, instr: imem_instruction};

    // Issue only if the word returning next cycle is guaranteed a free slot.
    assign has_room = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    assign issue = armed && !reset && !redirect_valid && (state == S_RUN)
                   && pc_ok && has_room;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_RUN;
        else       state <= state_nxt;
    end

    // Next state: redirect decides legality; otherwise a PC outside the window faults.
    always_comb begin
        state_nxt = state;
        if (redirect_valid)
            state_nxt = target_ok ? S_RUN : S_FAULT;
        else if ((state == S_RUN) && !pc_ok)
            state_nxt = S_FAULT;
    end

    // Outputs: read strobe/address and the sticky fault flag.
    always_comb begin
        imem_read_enable = issue;
        imem_address     = issue ? {pc[31:2], 2'b00} : 32'h0;
        fault            = (state == S_FAULT);
    end

    // PC, issue tracking and kill.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= BASE_ADDR;
            armed       <= 1'b0;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            kill        <= 1'b0;
        end else begin
            armed    <= 1'b1;
            inflight <= issue;
            kill     <= redirect_valid;
            if (issue)
                inflight_pc <= pc;
            if (redirect_valid)
                pc <= redirect_pc;
            else if (issue)
                pc <= pc + 32'd4;
        end
    end

    // Two-entry queue: shift on pop, write at the tail on push; redirect flushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            q0    <= '0;
            q1    <= '0;
            count <= 2'd0;
        end else if (redirect_valid) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) q0 <= ret;
                    else               q1 <= ret;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    q0    <= q1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q0 <= ret;
                    end else begin
                        q0 <= q1;
                        q1 <= ret;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
